sar_code_capture: RTL and testbench
===================================

// Module: sar_code_capture
// PURPOSE
//   Digital back-end directly downstream of the 10b SAR ADC macro. Synchronises the
//   asynchronous conversion-done flag READY into the CLK domain, captures the 11-bit
//   decision word B[10:0] (B10 = first/MSB decision), and optionally averages 2^AVG_LOG2
//   conversions. Results are buffered in a small FIFO and drained via valid/ready handshake.
// PARAMETERS
//   CODE_W    11  width of ADC decision word
//   AVG_LOG2  2   log2 of samples averaged per output (0 = pass-through)
//   DEPTH     4   FIFO depth in result words (power of 2, >=2)
// PORTS
//   CLK      in   1        system clock, all logic on rising edge
//   RST      in   1        synchronous reset, active-high
//   B        in   CODE_W   ADC decision bits {B10..B0}, stable while READY high
//   READY    in   1        ADC conversion done, async to CLK, high >=3 CLK periods
//   EN       in   1        capture enable; low = ignore conversions, clear averager
//   CLR_OVF  in   1        clears OVF sticky flag
//   DOUT     out  CODE_W   FIFO head result word
//   DVALID   out  1        DOUT valid (FIFO not empty)
//   DREADY   in   1        consumer accept; pop when DVALID & DREADY
//   OVF      out  1        sticky: a result was dropped on FIFO full
//   LEVEL    out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset: synchronous and active-high. RST high at a CLK edge -> DOUT=0, DVALID=0, OVF=0,
//     LEVEL=0, sync flops=0, accumulator=0, sample count=0. RST mid-conversion or mid-average
//     discards the partial sum. FIFO contents are discarded.
//   Sync: READY -> s1 -> s2 (2-flop sync), s3 = delayed s2; strobe = s2 & ~s3 & EN.
//     Exactly one strobe per READY rising edge. B is sampled in the strobe cycle.
//   Averager: acc width CODE_W+AVG_LOG2, cnt width AVG_LOG2.
//     On strobe with cnt < 2^AVG_LOG2-1: acc += B, cnt++.
//     On strobe with cnt = 2^AVG_LOG2-1: push (acc+B)>>AVG_LOG2 (truncate), acc=0, cnt=0.
//     AVG_LOG2=0: every strobe pushes B unchanged. No overflow is possible in acc.
//     EN low: acc=0, cnt=0 every cycle. FIFO still drains normally.
//   Latency: READY rises before edge k. The push occurs at edge k+2. DVALID rises after
//     edge k+2 if the FIFO was empty. DOUT is registered, with no combinational path B->DOUT.
//   FIFO: pop = DVALID & DREADY. Push and pop in the same cycle: both take effect,
//     LEVEL unchanged, including when full.
//     Push while full without pop: the new result is dropped, FIFO is unchanged, OVF=1.
//     OVF stays high until CLR_OVF or RST. CLR_OVF coincident with a drop: OVF=1 (set wins).
//     Pop while empty: no effect. Pointers wrap modulo DEPTH.
//   DOUT holds its last value when the FIFO becomes empty. DVALID=0 qualifies it.
// TESTING
//   1 RST 2 cycles, AVG_LOG2=0, B=11'h5A5, READY pulse -> DVALID=1 at edge k+2, DOUT=11'h5A5.
//   2 AVG_LOG2=2, codes 100,101,102,104 -> single push DOUT=101 (407>>2). No push after 3 codes.
//   3 DREADY=0, DEPTH=4, 5 conversions -> LEVEL=4, OVF=1, first 4 codes retained in order.
//     CLR_OVF pulse -> OVF=0.
//   4 FIFO full, DREADY=1 in the same cycle as a push -> LEVEL stays 4, no drop, OVF=0.
//   5 EN=0 during 3 conversions -> no pushes. EN=1 then 4 codes -> average uses only new codes.
//   6 RST after 2 of 4 averaged samples -> DVALID=0, LEVEL=0.
//     The next 4 codes 8,8,8,8 -> DOUT=8. READY held high 20 cycles -> one strobe only.

Source files
------------

// File: rtl/sar_code_capture.sv
// Back-end for the SAR ADC macro: synchronises READY, captures the decision word,
// optionally averages 2^AVG_LOG2 conversions and queues results in a small FIFO.
module sar_code_capture #(
   parameter int CODE_W   = 11,
   parameter int AVG_LOG2 = 2,
   parameter int DEPTH    = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CODE_W-1:0]        B,
   input  logic                     READY,
   input  logic                     EN,
   input  logic                     CLR_OVF,
   output logic [CODE_W-1:0]        DOUT,
   output logic                     DVALID,
   input  logic                     DREADY,
   output logic                     OVF,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int ACC_W    = CODE_W + AVG_LOG2;
   localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int LVL_W    = $clog2(DEPTH) + 1;
   localparam int NSAMP_M1 = (1 << AVG_LOG2) - 1;

   // Divide-by-2^AVG_LOG2 with truncation; acc is wide enough that no bits are lost before the shift.
   function automatic logic [CODE_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
      return CODE_W'(sum >> AVG_LOG2);
   endfunction

   logic                ready_p0;
   logic                ready_p1;
   logic                ready_p2;
   logic                vld_p2;

   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [ACC_W-1:0]    sum_p2;
   logic                last_p2;
   logic                push_req;
   logic [CODE_W-1:0]   push_data;

   logic [CODE_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_next;
   logic [LVL_W-1:0]    level;
   logic [LVL_W-1:0]    level_next;
   logic                full;
   logic                pop;
   logic                push_ok;
   logic                drop;
   logic [CODE_W-1:0]   dout_next;

   // Stage p0..p2: two-flop synchroniser plus edge-detect delay on READY
   always_ff @(posedge CLK) begin
      if (RST) begin
         ready_p0 <= 1'b0;
         ready_p1 <= 1'b0;
         ready_p2 <= 1'b0;
      end else begin
         ready_p0 <= READY;
         ready_p1 <= ready_p0;
         ready_p2 <= ready_p1;
      end
   end

   assign vld_p2 = ready_p1 & ~ready_p2 & EN;

   // Stage p2: B is sampled in the strobe cycle and folded into the running sum
   assign sum_p2    = acc + ACC_W'(B);
   assign last_p2   = (cnt == CNT_W'(NSAMP_M1));
   assign push_req  = vld_p2 & last_p2;
   assign push_data = avg_trunc(sum_p2);

   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         acc <= '0;
         cnt <= '0;
      end else if (vld_p2) begin
         if (last_p2) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum_p2;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Stage p3: result FIFO; a simultaneous pop frees the slot, so push-while-full-with-pop is not a drop
   assign full    = (level == LVL_W'(DEPTH));
   assign pop     = DVALID & DREADY;
   assign push_ok = push_req & (~full | pop);
   assign drop    = push_req & full & ~pop;
   assign rd_next = rd_ptr + PTR_W'(pop);

   always_comb begin
      level_next = level;
      if (push_ok && !pop)
         level_next = level + LVL_W'(1);
      else if (!push_ok && pop)
         level_next = level - LVL_W'(1);
   end

   // DOUT is a register that tracks the head; a push into an empty queue bypasses mem
   always_comb begin
      dout_next = DOUT;
      if (level_next != '0) begin
         if (push_ok && ((level - LVL_W'(pop)) == '0))
            dout_next = push_data;
         else
            dout_next = mem[rd_next];
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         DOUT   <= '0;
         OVF    <= 1'b0;
      end else begin
         rd_ptr <= rd_next;
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         level <= level_next;
         DOUT  <= dout_next;
         if (drop)
            OVF <= 1'b1;
         else if (CLR_OVF)
            OVF <= 1'b0;
      end
   end

   assign DVALID = (level != '0);
   assign LEVEL  = level;

endmodule

// File: tb/tb_sar_code_capture.sv
// Directed bench: one pass-through instance and one 4-sample averaging instance share stimulus.
module tb_sar_code_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] b = '0;
   logic        ready = 1'b0;
   logic        en = 1'b1;
   logic        clr_ovf = 1'b0;
   logic        dready = 1'b0;

   logic [10:0] dout0, dout2;
   logic        dvalid0, dvalid2;
   logic        ovf0, ovf2;
   logic [2:0]  level0, level2;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   sar_code_capture #(.CODE_W(11), .AVG_LOG2(0), .DEPTH(4)) dut0 (
      .CLK(clk), .RST(rst), .B(b), .READY(ready), .EN(en), .CLR_OVF(clr_ovf),
      .DOUT(dout0), .DVALID(dvalid0), .DREADY(dready), .OVF(ovf0), .LEVEL(level0)
   );

   sar_code_capture #(.CODE_W(11), .AVG_LOG2(2), .DEPTH(4)) dut2 (
      .CLK(clk), .RST(rst), .B(b), .READY(ready), .EN(en), .CLR_OVF(clr_ovf),
      .DOUT(dout2), .DVALID(dvalid2), .DREADY(dready), .OVF(ovf2), .LEVEL(level2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One conversion: READY high for 'hold' periods, then low long enough to re-arm the edge detector
   task automatic conv(input logic [10:0] code, input int hold);
      @(negedge clk);
      b = code;
      ready = 1'b1;
      repeat (hold) @(negedge clk);
      ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] exp3 [4];
      logic [10:0] exp4 [4];
      exp3[0] = 11'h011; exp3[1] = 11'h022; exp3[2] = 11'h033; exp3[3] = 11'h044;
      exp4[0] = 11'd2;   exp4[1] = 11'd3;   exp4[2] = 11'd4;   exp4[3] = 11'd5;

      // Reset state
      do_reset();
      chk("rst_dvalid", 32'(dvalid0), 32'd0);
      chk("rst_dout", 32'(dout0), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);
      chk("rst_level", 32'(level0), 32'd0);
      chk("rst_level_avg", 32'(level2), 32'd0);

      // Pass-through latency: READY set before edge k, DVALID after edge k+2
      @(negedge clk);
      b = 11'h5A5;
      ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("lat_k1_dvalid", 32'(dvalid0), 32'd0);
      @(posedge clk);
      #1 chk("lat_k2_dvalid", 32'(dvalid0), 32'd1);
      chk("lat_k2_dout", 32'(dout0), 32'h5A5);
      chk("lat_k2_level", 32'(level0), 32'd1);
      @(negedge clk);
      ready = 1'b0;
      repeat (3) @(negedge clk);

      // Averaging: 100,101,102,104 -> 407>>2 = 101
      do_reset();
      conv(11'd100, 4);
      conv(11'd101, 4);
      conv(11'd102, 4);
      chk("avg3_dvalid", 32'(dvalid2), 32'd0);
      chk("avg3_level", 32'(level2), 32'd0);
      conv(11'd104, 4);
      chk("avg4_dvalid", 32'(dvalid2), 32'd1);
      chk("avg4_dout", 32'(dout2), 32'd101);
      chk("avg4_level", 32'(level2), 32'd1);

      // Overflow: 5 conversions into a 4-deep FIFO with no consumer
      do_reset();
      conv(11'h011, 4);
      conv(11'h022, 4);
      conv(11'h033, 4);
      conv(11'h044, 4);
      chk("full_ovf_before", 32'(ovf0), 32'd0);
      conv(11'h055, 4);
      chk("ovf_level", 32'(level0), 32'd4);
      chk("ovf_flag", 32'(ovf0), 32'd1);
      dready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_order%0d", i), 32'(dout0), 32'(exp3[i]));
         chk($sformatf("ovf_dvalid%0d", i), 32'(dvalid0), 32'd1);
         @(negedge clk);
      end
      chk("drain_dvalid", 32'(dvalid0), 32'd0);
      chk("drain_dout_hold", 32'(dout0), 32'h044);
      @(negedge clk);
      chk("pop_empty_level", 32'(level0), 32'd0);
      dready = 1'b0;
      chk("ovf_sticky", 32'(ovf0), 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(ovf0), 32'd0);

      // Full FIFO with pop coincident with push: no drop
      do_reset();
      conv(11'd1, 4);
      conv(11'd2, 4);
      conv(11'd3, 4);
      conv(11'd4, 4);
      chk("full_level", 32'(level0), 32'd4);
      @(negedge clk);
      b = 11'd5;
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      dready = 1'b1;
      @(negedge clk);
      dready = 1'b0;
      chk("pushpop_level", 32'(level0), 32'd4);
      chk("pushpop_ovf", 32'(ovf0), 32'd0);
      chk("pushpop_head", 32'(dout0), 32'd2);
      @(negedge clk);
      ready = 1'b0;
      repeat (3) @(negedge clk);
      dready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pushpop_order%0d", i), 32'(dout0), 32'(exp4[i]));
         @(negedge clk);
      end
      dready = 1'b0;
      chk("pushpop_drained", 32'(level0), 32'd0);

      // EN low clears a partial average and blocks capture
      do_reset();
      conv(11'd1000, 4);
      conv(11'd1000, 4);
      en = 1'b0;
      conv(11'd50, 4);
      conv(11'd60, 4);
      conv(11'd70, 4);
      chk("en0_level_avg", 32'(level2), 32'd0);
      chk("en0_level_pass", 32'(level0), 32'd2);
      en = 1'b1;
      conv(11'd200, 4);
      conv(11'd204, 4);
      conv(11'd208, 4);
      conv(11'd213, 4);
      chk("en1_level", 32'(level2), 32'd1);
      chk("en1_dout", 32'(dout2), 32'd206);

      // Reset mid-average, then a long READY pulse yields exactly one strobe
      do_reset();
      conv(11'd500, 4);
      conv(11'd500, 4);
      chk("pre_rst_level", 32'(level0), 32'd2);
      do_reset();
      chk("midavg_rst_dvalid", 32'(dvalid2), 32'd0);
      chk("midavg_rst_level", 32'(level2), 32'd0);
      chk("midavg_rst_level_pass", 32'(level0), 32'd0);
      conv(11'd8, 4);
      conv(11'd8, 4);
      conv(11'd8, 4);
      conv(11'd8, 20);
      chk("long_dout", 32'(dout2), 32'd8);
      chk("long_level_avg", 32'(level2), 32'd1);
      chk("long_level_pass", 32'(level0), 32'd4);
      chk("long_ovf_pass", 32'(ovf0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
